// File: rtl/bias_add_pkg.sv
// Shared types and arithmetic helpers for the bias-add stream stage.
package bias_add_pkg;

    // Internal working width; wide enough for any realistic lane format.
    localparam int MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    // Occupancy of the 2-entry output skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_occ_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a value after moving it from from_frac to to_frac fractional bits.
    function automatic int aligned_width(input int w, input int from_frac, input int to_frac);
        return (to_frac > from_frac) ? w + (to_frac - from_frac) : w;
    endfunction

    // One guard bit above the wider operand, so the add can never overflow.
    function automatic int sum_width(input int a_w, input int b_w);
        return max_int(a_w, b_w) + 1;
    endfunction

    // Left shift to gain fractional bits; arithmetic right shift (toward -inf) to drop them.
    function automatic wide_t align_shift(input wide_t value, input int from_frac, input int to_frac);
        if (to_frac >= from_frac)
            return value <<< (to_frac - from_frac);
        else
            return value >>> (from_frac - to_frac);
    endfunction

    // Clamp a signed value of in_w significant bits into a signed out_w-bit range.
    function automatic wide_t sat_clip(input wide_t value, input int in_w, input int out_w);
        wide_t max_v;
        wide_t min_v;
        max_v = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
        min_v = -max_v - wide_t'(1);
        if (in_w <= out_w)
            return value;
        if (value > max_v)
            return max_v;
        if (value < min_v)
            return min_v;
        return value;
    endfunction

endpackage

// File: rtl/bias_add_stream_skid_buffer_2.sv
// Generic 2-entry valid/ready register FIFO. Accepts a new beat in the same
// cycle the head is popped even when both entries are occupied.
module skid_buffer_2
    import bias_add_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i
);

    skid_occ_e             occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  push, pop;

    // State register: occupancy and both data entries.
    // NOTE: both entries are reset (not just occupancy) so data_out reads 0 after reset instead of stale content.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            occ_q  <= SKID_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Next-state: head is always the oldest beat; tail only holds the second one.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        push   = in_valid_i & in_ready_o;
        pop    = out_valid_o & out_ready_i;
        unique case (occ_q)
            SKID_EMPTY: begin
                if (push) begin
                    head_d = in_data_i;
                    occ_d  = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    tail_d = in_data_i;
                    occ_d  = SKID_TWO;
                end else if (pop) begin
                    occ_d  = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push)
                        tail_d = in_data_i;
                    else
                        occ_d = SKID_ONE;
                end
            end
            default: occ_d = SKID_EMPTY;
        endcase
    end

    // Outputs: space is computed after the pop so a full buffer still streams.
    always_comb begin
        out_valid_o = (occ_q != SKID_EMPTY);
        out_data_o  = head_q;
        in_ready_o  = (occ_q != SKID_TWO) | (out_valid_o & out_ready_i);
    end

endmodule

// File: rtl/bias_add_stream.sv
// Joins the linear-core data stream with the streamed bias, adds them per lane
// with fractional alignment and saturation, and emits the result through a
// 2-entry skid buffer. Tracks the row column of the next join and a sticky
// saturation flag.
module bias_add_stream
    import bias_add_pkg::*;
#(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int DATA_IN_PRECISION_1  = 6,
    parameter int BIAS_PRECISION_0     = 16,
    parameter int BIAS_PRECISION_1     = 3,
    parameter int DATA_OUT_PRECISION_0 = 16,
    parameter int DATA_OUT_PRECISION_1 = 6,
    parameter int PARALLELISM          = 1,
    parameter int TENSOR_SIZE_DIM_0    = 32
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [PARALLELISM-1:0][DATA_IN_PRECISION_0-1:0]      data_in,
    input  logic                                                 data_in_valid,
    output logic                                                 data_in_ready,
    input  logic [PARALLELISM-1:0][BIAS_PRECISION_0-1:0]         bias,
    input  logic                                                 bias_valid,
    output logic                                                 bias_ready,
    output logic [PARALLELISM-1:0][DATA_OUT_PRECISION_0-1:0]     data_out,
    output logic                                                 data_out_valid,
    input  logic                                                 data_out_ready,
    output logic [$clog2(TENSOR_SIZE_DIM_0/PARALLELISM):0]       col_idx,
    output logic                                                 sat_flag
);

    localparam int DEPTH     = TENSOR_SIZE_DIM_0 / PARALLELISM;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int BIAS_AL_W = aligned_width(BIAS_PRECISION_0, BIAS_PRECISION_1, DATA_IN_PRECISION_1);
    localparam int SUM_WIDTH = sum_width(DATA_IN_PRECISION_0, BIAS_AL_W);
    localparam int REALIGN_W = aligned_width(SUM_WIDTH, DATA_IN_PRECISION_1, DATA_OUT_PRECISION_1);
    localparam int DW        = PARALLELISM * DATA_OUT_PRECISION_0;

    logic                   space;
    logic                   fire;
    logic [DW-1:0]          lane_flat;
    logic [PARALLELISM-1:0] lane_clip;
    logic                   any_clip;
    logic [CW-1:0]          col_idx_q, col_idx_d;
    logic                   sat_flag_q;

    // Join: each side is popped only when the other is also present.
    always_comb begin
        data_in_ready = bias_valid & space & ~rst;
        bias_ready    = data_in_valid & space & ~rst;
        fire          = data_in_valid & bias_valid & space & ~rst;
        any_clip      = |lane_clip;
        col_idx_d     = (col_idx_q == CW'(DEPTH - 1)) ? '0 : col_idx_q + CW'(1);
    end

    for (genvar g = 0; g < PARALLELISM; g++) begin : g_lane
        wide_t                        din_ext, bias_al, out_al, clipped;
        logic signed [SUM_WIDTH-1:0]  sum;
        logic [DATA_OUT_PRECISION_0-1:0] res;
        logic                         clip;

        // Per-lane align, add, realign and saturate.
        always_comb begin
            din_ext = wide_t'(signed'(data_in[g]));
            bias_al = align_shift(wide_t'(signed'(bias[g])), BIAS_PRECISION_1, DATA_IN_PRECISION_1);
            sum     = SUM_WIDTH'(din_ext + bias_al);
            out_al  = align_shift(wide_t'(sum), DATA_IN_PRECISION_1, DATA_OUT_PRECISION_1);
            clipped = sat_clip(out_al, REALIGN_W, DATA_OUT_PRECISION_0);
            res     = clipped[DATA_OUT_PRECISION_0-1:0];
            clip    = (clipped != out_al);
        end

        assign lane_flat[g*DATA_OUT_PRECISION_0 +: DATA_OUT_PRECISION_0] = res;
        assign lane_clip[g] = clip;
    end

    skid_buffer_2 #(
        .DATA_WIDTH(DW)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (fire),
        .in_data_i  (lane_flat),
        .in_ready_o (space),
        .out_valid_o(data_out_valid),
        .out_data_o (data_out),
        .out_ready_i(data_out_ready)
    );

    // Column counter advances on each join; sticky flag records any clipped lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx_q  <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            if (fire)
                col_idx_q <= col_idx_d;
            if (fire && any_clip)
                sat_flag_q <= 1'b1;
        end
    end

    assign col_idx  = col_idx_q;
    assign sat_flag = sat_flag_q;

endmodule

// File: tb/tb_bias_add_stream.sv
// Self-checking bench for bias_add_stream: directed scenarios plus a random
// stream compared against an arithmetic reference model and scoreboard.
module tb_bias_add_stream;

    localparam int DIN_W  = 16;
    localparam int DIN_F  = 6;
    localparam int BIAS_W = 16;
    localparam int BIAS_F = 3;
    localparam int DOUT_W = 16;
    localparam int DOUT_F = 6;
    localparam int PAR    = 1;
    localparam int TSIZE  = 32;
    localparam int DEPTH  = TSIZE / PAR;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [PAR-1:0][DIN_W-1:0]    data_in;
    logic                         data_in_valid;
    logic                         data_in_ready;
    logic [PAR-1:0][BIAS_W-1:0]   bias;
    logic                         bias_valid;
    logic                         bias_ready;
    logic [PAR-1:0][DOUT_W-1:0]   data_out;
    logic                         data_out_valid;
    logic                         data_out_ready;
    logic [CW-1:0]                col_idx;
    logic                         sat_flag;

    int checks = 0;
    int errors = 0;

    logic [DOUT_W-1:0] exp_q[$];
    logic [DOUT_W-1:0] got_q[$];
    int model_col = 0;
    bit model_sat = 0;
    int data_pops = 0;
    int bias_pops = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    bias_add_stream #(
        .DATA_IN_PRECISION_0 (DIN_W),
        .DATA_IN_PRECISION_1 (DIN_F),
        .BIAS_PRECISION_0    (BIAS_W),
        .BIAS_PRECISION_1    (BIAS_F),
        .DATA_OUT_PRECISION_0(DOUT_W),
        .DATA_OUT_PRECISION_1(DOUT_F),
        .PARALLELISM         (PAR),
        .TENSOR_SIZE_DIM_0   (TSIZE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .bias          (bias),
        .bias_valid    (bias_valid),
        .bias_ready    (bias_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .col_idx       (col_idx),
        .sat_flag      (sat_flag)
    );

    // Reference: real-valued add expressed in integer units of the output LSB.
    function automatic longint ref_sum(input logic [DIN_W-1:0] d, input logic [BIAS_W-1:0] b);
        longint dv, bv, s;
        dv = longint'($signed(d));
        bv = longint'($signed(b));
        if (DIN_F >= BIAS_F) bv = bv * (longint'(1) << (DIN_F - BIAS_F));
        else                 bv = bv >>> (BIAS_F - DIN_F);
        s = dv + bv;
        if (DOUT_F >= DIN_F) s = s * (longint'(1) << (DOUT_F - DIN_F));
        else                 s = s >>> (DIN_F - DOUT_F);
        return s;
    endfunction

    function automatic bit ref_clip(input logic [DIN_W-1:0] d, input logic [BIAS_W-1:0] b);
        longint s, hi, lo;
        s  = ref_sum(d, b);
        hi = (longint'(1) << (DOUT_W - 1)) - 1;
        lo = -hi - 1;
        return (s > hi) || (s < lo);
    endfunction

    function automatic logic [DOUT_W-1:0] ref_out(input logic [DIN_W-1:0] d, input logic [BIAS_W-1:0] b);
        longint s, hi, lo;
        s  = ref_sum(d, b);
        hi = (longint'(1) << (DOUT_W - 1)) - 1;
        lo = -hi - 1;
        if (s > hi)      s = hi;
        else if (s < lo) s = lo;
        return s[DOUT_W-1:0];
    endfunction

    // Monitor: records accepted input pairs (as model results) and emitted outputs.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            got_q.delete();
            model_col = 0;
            model_sat = 0;
        end else begin
            if (data_out_valid && data_out_ready)
                got_q.push_back(data_out[0]);
            if (data_in_valid && data_in_ready) begin
                exp_q.push_back(ref_out(data_in[0], bias[0]));
                if (ref_clip(data_in[0], bias[0])) model_sat = 1;
                model_col = (model_col + 1) % DEPTH;
                data_pops++;
            end
            if (bias_valid && bias_ready)
                bias_pops++;
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        data_in_valid = 1'b0;
        bias_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one pair starting at the current negedge; returns at the negedge after it joins.
    task automatic send(input logic [DIN_W-1:0] d, input logic [BIAS_W-1:0] b);
        bit fired;
        fired = 0;
        data_in[0] = d;
        bias[0] = b;
        data_in_valid = 1'b1;
        bias_valid = 1'b1;
        for (int i = 0; i < 50 && !fired; i++) begin
            @(posedge clk);
            fired = data_in_valid && data_in_ready && bias_ready;
            @(negedge clk);
        end
        data_in_valid = 1'b0;
        bias_valid = 1'b0;
        if (!fired) begin
            checks++; errors++;
            $display("FAIL send_timeout data=%h bias=%h never joined", d, b);
        end
    endtask

    task automatic drain_wait;
        data_out_ready = 1'b1;
        for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++)
            @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        data_in_valid = 1'b1;
        bias_valid = 1'b1;
        data_in[0] = 16'h0040;
        bias[0] = 16'h0008;
        data_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL reset_data_in_ready got %b want 0", data_in_ready); end
        checks++; if (bias_ready !== 1'b0) begin errors++; $display("FAIL reset_bias_ready got %b want 0", bias_ready); end
        @(negedge clk);
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", data_out_valid); end
        checks++; if (data_out[0] !== 16'h0000) begin errors++; $display("FAIL reset_data_out got %h want 0000", data_out[0]); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
        checks++; if (col_idx !== '0) begin errors++; $display("FAIL reset_col_idx got %0d want 0", col_idx); end
        data_in_valid = 1'b0;
        bias_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        data_out_ready = 1'b1;
        send(16'h0040, 16'h0008);
        checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency valid got %b want 1", data_out_valid); end
        checks++; if (data_out[0] !== 16'h0080) begin errors++; $display("FAIL basic_add got %h want 0080", data_out[0]); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL basic_sat got %b want 0", sat_flag); end
        @(negedge clk);
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_dup valid got %b want 0", data_out_valid); end
    endtask

    task automatic test_negative;
        data_out_ready = 1'b1;
        send(16'hFFC0, 16'hFFF8);
        checks++; if (data_out[0] !== 16'hFF80) begin errors++; $display("FAIL neg_both got %h want ff80", data_out[0]); end
        send(16'h0040, 16'hFFF8);
        checks++; if (data_out[0] !== 16'h0000) begin errors++; $display("FAIL neg_cancel got %h want 0000", data_out[0]); end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        data_out_ready = 1'b1;
        send(16'h7FF0, 16'h0100);
        checks++; if (data_out[0] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got %h want 7fff", data_out[0]); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set got %b want 1", sat_flag); end
        send(16'h8010, 16'hFF00);
        checks++; if (data_out[0] !== 16'h8000) begin errors++; $display("FAIL sat_neg got %h want 8000", data_out[0]); end
        send(16'h0040, 16'h0008);
        checks++; if (data_out[0] !== 16'h0080) begin errors++; $display("FAIL sat_after_normal got %h want 0080", data_out[0]); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_sticky got %b want 1", sat_flag); end
        @(negedge clk);
    endtask

    task automatic test_join_gating;
        bit saw_ready;
        int pops0, cyc0, nb;
        do_reset();
        data_out_ready = 1'b1;
        saw_ready = 0;
        pops0 = bias_pops;
        bias[0] = 16'($urandom);
        bias_valid = 1'b1;
        data_in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bias_ready) saw_ready = 1;
        end
        checks++; if (saw_ready) begin errors++; $display("FAIL gate_bias_alone bias_ready seen 1 want 0"); end
        checks++; if (col_idx !== '0) begin errors++; $display("FAIL gate_col_idx got %0d want 0", col_idx); end
        checks++; if (bias_pops != pops0) begin errors++; $display("FAIL gate_bias_pops got %0d want %0d", bias_pops, pops0); end
        bias_valid = 1'b0;
        data_in_valid = 1'b1;
        saw_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (data_in_ready) saw_ready = 1;
        end
        checks++; if (saw_ready) begin errors++; $display("FAIL gate_data_alone data_in_ready seen 1 want 0"); end
        data_in_valid = 1'b0;
        exp_q.delete();
        got_q.delete();
        pops0 = bias_pops;
        cyc0 = cyc;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (col_idx !== CW'(i)) begin errors++; $display("FAIL row_col_idx beat %0d got %0d want %0d", i, col_idx, i); end
            send(16'($urandom), 16'($urandom));
        end
        checks++; if (col_idx !== '0) begin errors++; $display("FAIL row_wrap got %0d want 0", col_idx); end
        checks++; if (bias_pops - pops0 != DEPTH) begin errors++; $display("FAIL row_bias_pops got %0d want %0d", bias_pops - pops0, DEPTH); end
        checks++; if (cyc - cyc0 != DEPTH) begin errors++; $display("FAIL row_throughput cycles got %0d want %0d", cyc - cyc0, DEPTH); end
        drain_wait();
        nb = exp_q.size();
        checks++; if (got_q.size() != DEPTH || nb != DEPTH) begin errors++; $display("FAIL row_count got %0d out, %0d in, want %0d", got_q.size(), nb, DEPTH); end
        for (int i = 0; i < nb && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL row_data beat %0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure;
        logic [DIN_W-1:0]  d[8];
        logic [BIAS_W-1:0] b[8];
        logic [DOUT_W-1:0] held;
        int idx, pops0, cyc0;
        bit fired;
        for (int i = 0; i < 8; i++) begin
            d[i] = 16'($urandom);
            b[i] = 16'($urandom_range(0, 255));
        end
        exp_q.delete();
        got_q.delete();
        held = '0;
        data_out_ready = 1'b0;
        pops0 = data_pops;
        idx = 0;
        data_in[0] = d[0];
        bias[0] = b[0];
        data_in_valid = 1'b1;
        bias_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            fired = data_in_valid && data_in_ready;
            @(negedge clk);
            if (fired) begin
                idx++;
                if (idx == 1) held = data_out[0];
                data_in[0] = d[idx];
                bias[0] = b[idx];
            end
        end
        checks++; if (data_pops - pops0 != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", data_pops - pops0); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL bp_data_in_ready got %b want 0", data_in_ready); end
        checks++; if (bias_ready !== 1'b0) begin errors++; $display("FAIL bp_bias_ready got %b want 0", bias_ready); end
        checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", data_out_valid); end
        checks++; if (data_out[0] !== held) begin errors++; $display("FAIL bp_hold got %h want %h", data_out[0], held); end
        checks++; if (data_out[0] !== ref_out(d[0], b[0])) begin errors++; $display("FAIL bp_head got %h want %h", data_out[0], ref_out(d[0], b[0])); end
        data_out_ready = 1'b1;
        cyc0 = cyc;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            @(posedge clk);
            fired = data_in_valid && data_in_ready;
            @(negedge clk);
            if (fired) begin
                idx++;
                if (idx < 8) begin
                    data_in[0] = d[idx];
                    bias[0] = b[idx];
                end
            end
        end
        data_in_valid = 1'b0;
        bias_valid = 1'b0;
        checks++; if (cyc - cyc0 != 6) begin errors++; $display("FAIL bp_release_rate cycles got %0d want 6", cyc - cyc0); end
        drain_wait();
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== ref_out(d[i], b[i])) begin errors++; $display("FAIL bp_order beat %0d got %h want %h", i, got_q[i], ref_out(d[i], b[i])); end
        end
    endtask

    task automatic test_random;
        int nb;
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < 400; c++) begin
            data_in[0] = 16'($urandom);
            bias[0] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(8'($urandom)));
            data_in_valid = ($urandom_range(0, 3) != 0);
            bias_valid = ($urandom_range(0, 3) != 0);
            data_out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        data_in_valid = 1'b0;
        bias_valid = 1'b0;
        drain_wait();
        nb = exp_q.size();
        checks++; if (got_q.size() != nb || nb == 0) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), nb); end
        for (int i = 0; i < nb && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data beat %0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (sat_flag !== model_sat) begin errors++; $display("FAIL rand_sat_flag got %b want %b", sat_flag, model_sat); end
        checks++; if (col_idx !== CW'(model_col)) begin errors++; $display("FAIL rand_col_idx got %0d want %0d", col_idx, model_col); end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        data_out_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            send(16'($urandom_range(0, 1023)), 16'($urandom_range(0, 127)));
        drain_wait();
        data_out_ready = 1'b0;
        send(16'h7FF0, 16'h0100);
        send(16'h0040, 16'h0008);
        checks++; if (col_idx !== CW'(17)) begin errors++; $display("FAIL mid_col_idx got %0d want 17", col_idx); end
        checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered valid got %b want 1", data_out_valid); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL mid_sat_before got %b want 1", sat_flag); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", data_out_valid); end
        checks++; if (col_idx !== '0) begin errors++; $display("FAIL mid_rst_col got %0d want 0", col_idx); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL mid_rst_sat got %b want 0", sat_flag); end
        checks++; if (data_out[0] !== 16'h0000) begin errors++; $display("FAIL mid_rst_data got %h want 0000", data_out[0]); end
        rst = 1'b0;
        data_out_ready = 1'b1;
        send(16'h0040, 16'h0010);
        checks++; if (data_out_valid !== 1'b1 || data_out[0] !== 16'h00C0) begin errors++; $display("FAIL mid_first_pair got %b/%h want 1/00c0", data_out_valid, data_out[0]); end
        checks++; if (col_idx !== CW'(1)) begin errors++; $display("FAIL mid_first_col got %0d want 1", col_idx); end
        @(negedge clk);
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale valid got %b want 0", data_out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        data_in = '0;
        bias = '0;
        data_in_valid = 1'b0;
        bias_valid = 1'b0;
        data_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_join_gating();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
